pc_branch_sequencer: RTL and testbench
======================================

# pc_branch_sequencer

Program-counter register and branch resolver for the multi-cycle datapath. Consumes the held ALU zero flag produced by the zero-holster stage and decides the next PC for sequential, jump and conditional-branch (beq/bne) instructions. Branches resolve in a dedicated cycle so the zero flag is sampled only after the ALU compare has settled and been captured. Output PC drives instruction memory and the PC+2 link path.

## Interface

- WIDTH, 16, PC and address width in bits
- RESET_PC, 16'h0000, PC value loaded on reset

- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- PCWrite  input  1  control-unit strobe: advance PC this cycle
- Stall  input  1  freeze all state (PC, FSM, captured fields, counters)
- Jump  input  1  unconditional jump, qualified by PCWrite
- BranchEq  input  1  branch-if-zero request, qualified by PCWrite
- BranchNe  input  1  branch-if-not-zero request, qualified by PCWrite
- Holster  input  1  held zero flag from the zero-holster stage
- Offset  input  WIDTH  signed word offset, sign-extended by the decoder
- JumpTarget  input  WIDTH  absolute byte address for Jump
- PC  output  WIDTH  current PC
- PCPrev  output  WIDTH  PC before the most recent update
- Busy  output  1  high while a branch is in RESOLVE
- BranchTaken  output  1  one-cycle pulse when a resolved branch is taken
- BranchCount  output  16  branches resolved (stats build only)
- TakenCount  output  16  branches taken (stats build only)

## Operation

- States: RUN, RESOLVE. Reset state RUN.
- Reset values: PC=RESET_PC, PCPrev=RESET_PC, Busy=0, BranchTaken=0, counters=0, captured fields=0.
- Stall=1 (not reset): no register changes; BranchTaken forced 0 that cycle; PCWrite/Jump/Branch* ignored.
- RUN, PCWrite=1, priority Jump > BranchEq > BranchNe > sequential:
  - Jump: PC<=JumpTarget, PCPrev<=PC; stay RUN.
  - BranchEq or BranchNe: capture Offset and type (Ne=1 only if BranchEq=0); PC unchanged; go RESOLVE; Busy=1 next cycle.
  - none: PC<=PC+2, PCPrev<=PC.
- RUN, PCWrite=0: hold.
- RESOLVE (PCWrite and requests ignored): taken = Holster for Eq, !Holster for Ne. Taken: PC<=PC+2+(Offset<<1); else PC<=PC+2. PCPrev<=PC; BranchTaken<=taken; return RUN.
- Arithmetic modulo 2^WIDTH; overflow and negative wrap silently; Offset<<1 discards MSB.
- Both BranchEq and BranchNe high: treated as BranchEq.

## Timing

- Sequential and jump updates: 1 cycle after PCWrite edge.
- Branch: 2 cycles from PCWrite edge to final PC; Busy high exactly the RESOLVE cycle (when unstalled).
- Holster sampled at the clock edge ending RESOLVE; upstream must hold it stable that cycle.
- BranchTaken registered, high for the cycle after RESOLVE completes.
- rst during RESOLVE: branch aborted, RUN, PC=RESET_PC, no counter increment.
- rst dominates Stall.

## Configuration

- BRANCH_STATS_EN defined: BranchCount increments on every completed RESOLVE, TakenCount on every taken one; both saturate at 16'hFFFF; cleared by rst; frozen by Stall.
- Undefined: counter registers not built; BranchCount and TakenCount ports tied to 0.

## Test plan

- rst=1 one cycle, then PCWrite=1 three cycles -> PC 0000, 0002, 0004, 0006; PCPrev trails by one; Busy=0.
- PC=0010, BranchEq, Offset=0004, Holster=1 in RESOLVE -> Busy=1 one cycle, PC=001A, BranchTaken pulse, PCPrev=0010.
- PC=0010, BranchNe, Offset=FFFC, Holster=1 -> PC=0012, BranchTaken=0; repeat with Holster=0 -> PC=000A, BranchTaken=1.
- Jump+BranchEq together, JumpTarget=0100 -> PC=0100 next cycle, no RESOLVE; PC=FFFE sequential -> PC=0000.
- Stall=1 for 3 cycles during RESOLVE -> PC, Busy, counters frozen; resolves the cycle after Stall drops; rst in RESOLVE -> PC=0000, RUN.
- BRANCH_STATS_EN: 3 branches, 2 taken -> BranchCount=3, TakenCount=2; preload near FFFF -> saturates; without macro both read 0.

Source files
------------

// File: rtl/pc_branch_sequencer.sv
// Program counter and two-phase branch resolver for the multi-cycle datapath.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_branch_sequencer #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             BranchEq,
  input  logic             BranchNe,
  input  logic             Holster,
  input  logic [WIDTH-1:0] Offset,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPrev,
  output logic             Busy,
  output logic             BranchTaken,
  output logic [15:0]      BranchCount,
  output logic [15:0]      TakenCount
);

  typedef enum logic {
    RUN     = 1'b0,
    RESOLVE = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_prev_q;
  logic [WIDTH-1:0] offset_q;
  logic             is_ne_q;
  logic             busy_q;
  logic             taken_q;

  logic [WIDTH-1:0] pc_seq_d;
  logic [WIDTH-1:0] pc_br_d;
  logic             taken_d;

  // Offset is a word offset; the shift drops its MSB and all sums wrap.
  assign pc_seq_d = pc_q + WIDTH'(2);
  assign pc_br_d  = pc_seq_d + (offset_q << 1);
  assign taken_d  = is_ne_q ? ~Holster : Holster;

  // NOTE: every state register uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pc_prev_q <= RESET_PC;
      offset_q  <= '0;
      is_ne_q   <= 1'b0;
      busy_q    <= 1'b0;
      taken_q   <= 1'b0;
    end else if (Stall) begin
      taken_q <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (PCWrite) begin
            if (Jump) begin
              pc_q      <= JumpTarget;
              pc_prev_q <= pc_q;
            end else if (BranchEq || BranchNe) begin
              offset_q <= Offset;
              is_ne_q  <= ~BranchEq;
              busy_q   <= 1'b1;
              state_q  <= RESOLVE;
            end else begin
              pc_q      <= pc_seq_d;
              pc_prev_q <= pc_q;
            end
          end
        end
        RESOLVE: begin
          pc_q      <= taken_d ? pc_br_d : pc_seq_d;
          pc_prev_q <= pc_q;
          taken_q   <= taken_d;
          busy_q    <= 1'b0;
          state_q   <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign PC          = pc_q;
  assign PCPrev      = pc_prev_q;
  assign Busy        = busy_q;
  assign BranchTaken = taken_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] taken_cnt_q;

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (!Stall && state_q == RESOLVE) begin
      if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
      if (taken_d && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign TakenCount  = taken_cnt_q;
`else
  assign BranchCount = 16'h0000;
  assign TakenCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed scoreboard bench for pc_branch_sequencer; expectations are queued
// as stimulus is applied and compared one cycle later.
module tb_pc_branch_sequencer;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        Stall;
  logic        Jump;
  logic        BranchEq;
  logic        BranchNe;
  logic        Holster;
  logic [15:0] Offset;
  logic [15:0] JumpTarget;
  logic [15:0] PC;
  logic [15:0] PCPrev;
  logic        Busy;
  logic        BranchTaken;
  logic [15:0] BranchCount;
  logic [15:0] TakenCount;

  pc_branch_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCWrite    (PCWrite),
    .Stall      (Stall),
    .Jump       (Jump),
    .BranchEq   (BranchEq),
    .BranchNe   (BranchNe),
    .Holster    (Holster),
    .Offset     (Offset),
    .JumpTarget (JumpTarget),
    .PC         (PC),
    .PCPrev     (PCPrev),
    .Busy       (Busy),
    .BranchTaken(BranchTaken),
    .BranchCount(BranchCount),
    .TakenCount (TakenCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [15:0] prev;
    logic        busy;
    logic        taken;
    logic [15:0] bcnt;
    logic [15:0] tcnt;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_bc = 16'h0000;
  logic [15:0] exp_tc = 16'h0000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expected post-edge state, advance one clock, compare.
  task automatic step(input string tag, input logic [15:0] pc, input logic [15:0] prev,
                      input logic busy, input logic taken);
    exp_t e;
    e.tag = tag; e.pc = pc; e.prev = prev; e.busy = busy; e.taken = taken;
    e.bcnt = exp_bc; e.tcnt = exp_tc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pc"},    PC, e.pc);
      check({e.tag, "_prev"},  PCPrev, e.prev);
      check({e.tag, "_busy"},  {15'd0, Busy}, {15'd0, e.busy});
      check({e.tag, "_taken"}, {15'd0, BranchTaken}, {15'd0, e.taken});
      check({e.tag, "_bcnt"},  BranchCount, e.bcnt);
      check({e.tag, "_tcnt"},  TakenCount, e.tcnt);
    end
  endtask

  // Expected counter update for a RESOLVE that completes on the next edge.
  task automatic count_branch(input logic taken);
`ifdef BRANCH_STATS_EN
    if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    if (taken && exp_tc != 16'hFFFF) exp_tc = exp_tc + 16'd1;
`else
    if (taken) exp_bc = exp_bc;
`endif
  endtask

  task automatic idle();
    PCWrite = 0; Jump = 0; BranchEq = 0; BranchNe = 0;
  endtask

  initial begin
    rst = 1; Stall = 0; Holster = 0; Offset = 16'h0000; JumpTarget = 16'h0000;
    idle();
    step("reset", 16'h0000, 16'h0000, 0, 0);

    rst = 0; PCWrite = 1;
    step("seq1", 16'h0002, 16'h0000, 0, 0);
    step("seq2", 16'h0004, 16'h0002, 0, 0);
    step("seq3", 16'h0006, 16'h0004, 0, 0);

    Jump = 1; JumpTarget = 16'h0010;
    step("jmp10a", 16'h0010, 16'h0006, 0, 0);

    // beq taken, +4 words
    Jump = 0; BranchEq = 1; Offset = 16'h0004;
    step("beq_busy", 16'h0010, 16'h0006, 1, 0);
    idle(); Holster = 1; count_branch(1);
    step("beq_res", 16'h001A, 16'h0010, 0, 1);
    step("beq_after", 16'h001A, 16'h0010, 0, 0);

    // bne not taken
    PCWrite = 1; Jump = 1; JumpTarget = 16'h0010;
    step("jmp10b", 16'h0010, 16'h001A, 0, 0);
    Jump = 0; BranchNe = 1; Offset = 16'hFFFC;
    step("bne_nt_busy", 16'h0010, 16'h001A, 1, 0);
    idle(); Holster = 1; count_branch(0);
    step("bne_nt_res", 16'h0012, 16'h0010, 0, 0);

    // bne taken, negative offset
    PCWrite = 1; Jump = 1; JumpTarget = 16'h0010;
    step("jmp10c", 16'h0010, 16'h0012, 0, 0);
    Jump = 0; BranchNe = 1; Offset = 16'hFFFC;
    step("bne_t_busy", 16'h0010, 16'h0012, 1, 0);
    idle(); Holster = 0; count_branch(1);
    step("bne_t_res", 16'h000A, 16'h0010, 0, 1);

    // Jump wins over a simultaneous branch request
    PCWrite = 1; Jump = 1; BranchEq = 1; JumpTarget = 16'h0100;
    step("jmp_prio", 16'h0100, 16'h000A, 0, 0);
    idle();
    step("jmp_noresolve", 16'h0100, 16'h000A, 0, 0);

    // Sequential wrap
    PCWrite = 1; Jump = 1; JumpTarget = 16'hFFFE;
    step("jmp_fffe", 16'hFFFE, 16'h0100, 0, 0);
    Jump = 0;
    step("seq_wrap", 16'h0000, 16'hFFFE, 0, 0);

    // Stall held across RESOLVE
    BranchEq = 1; Offset = 16'h0001; Holster = 0;
    step("stl_busy", 16'h0000, 16'hFFFE, 1, 0);
    idle(); PCWrite = 1; Stall = 1;
    step("stl_1", 16'h0000, 16'hFFFE, 1, 0);
    step("stl_2", 16'h0000, 16'hFFFE, 1, 0);
    step("stl_3", 16'h0000, 16'hFFFE, 1, 0);
    Stall = 0; PCWrite = 0; Holster = 1; count_branch(1);
    step("stl_res", 16'h0004, 16'h0000, 0, 1);

    // Reset aborts RESOLVE and dominates Stall
    PCWrite = 1; BranchNe = 1; Offset = 16'h0005;
    step("rst_busy", 16'h0004, 16'h0000, 1, 0);
    idle(); rst = 1; Stall = 1;
    exp_bc = 16'h0000; exp_tc = 16'h0000;
    step("rst_abort", 16'h0000, 16'h0000, 0, 0);
    rst = 0; Stall = 0;
    step("rst_idle", 16'h0000, 16'h0000, 0, 0);
    PCWrite = 1;
    step("rst_run", 16'h0002, 16'h0000, 0, 0);

    // Three branches, two taken
    BranchEq = 1; Offset = 16'h0000;
    step("cnt1_busy", 16'h0002, 16'h0000, 1, 0);
    idle(); Holster = 1; count_branch(1);
    step("cnt1_res", 16'h0004, 16'h0002, 0, 1);
    PCWrite = 1; BranchNe = 1;
    step("cnt2_busy", 16'h0004, 16'h0002, 1, 0);
    idle(); Holster = 1; count_branch(0);
    step("cnt2_res", 16'h0006, 16'h0004, 0, 0);
    PCWrite = 1; BranchNe = 1;
    step("cnt3_busy", 16'h0006, 16'h0004, 1, 0);
    idle(); Holster = 0; count_branch(1);
    step("cnt3_res", 16'h0008, 16'h0006, 0, 1);

    // Counter saturation from a preloaded value
`ifdef BRANCH_STATS_EN
    dut.branch_cnt_q = 16'hFFFE;
    dut.taken_cnt_q  = 16'hFFFE;
    exp_bc = 16'hFFFE; exp_tc = 16'hFFFE;
`endif
    PCWrite = 1; BranchEq = 1;
    step("sat1_busy", 16'h0008, 16'h0006, 1, 0);
    idle(); Holster = 1; count_branch(1);
    step("sat1_res", 16'h000A, 16'h0008, 0, 1);
    PCWrite = 1; BranchEq = 1;
    step("sat2_busy", 16'h000A, 16'h0008, 1, 0);
    idle(); Holster = 1; count_branch(1);
    step("sat2_res", 16'h000C, 16'h000A, 0, 1);

    check("sb_drained", 16'(sb.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
